note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_seq_pkg.sv | 65 ++++++
 rtl/note_fifo.sv | 82 ++++++++
 rtl/note_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_note_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer.
//
// Contents:
//   NOTE_W, OCT_W, BEATS_W, EVENT_W   event field widths
//   FREQ_W                            width of the integer frequency output
//   REST_NOTE                         note code that means silence
//   state_e                           sequencer FSM states
//   note_event_t                      one queued event {note, octave, beats}
//   baseX100()                        octave-3 pitch table in centi-Hz
//   noteFreq()                        integer Hz for a note/octave pair
package note_seq_pkg;

    localparam int NOTE_W  = 4;
    localparam int OCT_W   = 2;
    localparam int BEATS_W = 4;
    localparam int EVENT_W = NOTE_W + OCT_W + BEATS_W;
    localparam int FREQ_W  = 20;

    localparam logic [NOTE_W-1:0] REST_NOTE = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } state_e;

    typedef struct packed {
        logic [NOTE_W-1:0]  note;
        logic [OCT_W-1:0]   octave;
        logic [BEATS_W-1:0] beats;
    } note_event_t;

    // Octave-3 pitches scaled by 100. Codes 12..14 alias C, C#, D, and the
    // rest code falls to zero so a rest naturally yields 0 Hz.
    function automatic logic [14:0] baseX100(input logic [NOTE_W-1:0] note);
        logic [14:0] base;
        case (note)
            4'd0,  4'd12: base = 15'd13081;
            4'd1,  4'd13: base = 15'd13859;
            4'd2,  4'd14: base = 15'd14683;
            4'd3:         base = 15'd15556;
            4'd4:         base = 15'd16481;
            4'd5:         base = 15'd17461;
            4'd6:         base = 15'd18500;
            4'd7:         base = 15'd19600;
            4'd8:         base = 15'd20765;
            4'd9:         base = 15'd22000;
            4'd10:        base = 15'd23308;
            4'd11:        base = 15'd24694;
            default:      base = 15'd0;
        endcase
        return base;
    endfunction

    // Shift up by the octave offset first, then divide, so the result is the
    // floor of the exact scaled pitch (largest case 24694*8/100 = 1975).
    function automatic logic [FREQ_W-1:0] noteFreq(input logic [NOTE_W-1:0] note,
                                                   input logic [OCT_W-1:0]  octave);
        logic [17:0] scaled;
        scaled = {3'b000, baseX100(note)} << octave;
        return FREQ_W'(scaled / 18'd100);
    endfunction

endpackage

// File: rtl/note_fifo.sv
// First-word-fall-through event queue for the note sequencer.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, empties the queue
//   flush_i  synchronous clear; wins over push and pop in the same cycle
//   push_i   write data_i when not full
//   data_i   event to store
//   pop_i    discard the head entry when not empty
//   data_o   head entry, valid whenever empty_o is low
//   empty_o  no entries stored
//   full_o   DEPTH entries stored
module note_fifo
    import note_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = EVENT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush;
    logic             doPop;

    // Occupancy flags come straight from the registered count, so an entry
    // written this cycle is only visible to the reader from the next cycle.
    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == (PTR_W+1)'(DEPTH));
        doPush  = push_i && !full_o && !flush_i;
        doPop   = pop_i && !empty_o && !flush_i;
        data_o  = mem_q[rdPtr_q];
    end

    // Pointer and count bookkeeping. DEPTH is a power of two, so the
    // pointers simply wrap; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Queued square-wave note player.
//
// Events {note, octave, beats} are queued through a valid/ready port and
// played one after another: each event sounds a square wave at its pitch for
// beats*TICKS_PER_BEAT enabled cycles, optionally followed by GAP_TICKS
// silent cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   event offered
//   in_ready   queue not full
//   in_note    semitone 0..11 (12..14 alias 0..2, 15 = rest)
//   in_octave  octave offset above octave 3
//   in_beats   duration in beats, 0 discards the event
//   enable     low freezes playback; enqueueing continues
//   flush      synchronous clear of queue and current event
//   tone_out   square wave, low when silent
//   cur_freq   integer Hz of the sounding event, 0 when silent
//   busy       FSM not in IDLE
//   note_done  one-cycle pulse when an event completes or is discarded
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICKS_PER_BEAT = 12_500_000,
    parameter int GAP_TICKS      = 0,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NOTE_W-1:0]  in_note,
    input  logic [OCT_W-1:0]   in_octave,
    input  logic [BEATS_W-1:0] in_beats,
    input  logic               enable,
    input  logic               flush,
    output logic               tone_out,
    output logic [FREQ_W-1:0]  cur_freq,
    output logic               busy,
    output logic               note_done
);

    localparam int ACC_W  = 27;
    localparam int TICK_W = 24;
    localparam int GAP_W  = 32;

    localparam logic [ACC_W-1:0]  CLK_HZ_C  = ACC_W'(CLK_HZ);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
    localparam bit                HAS_GAP   = (GAP_TICKS > 0);

    state_e             state_q;
    logic [BEATS_W-1:0] beatCnt_q;
    logic [TICK_W-1:0]  tickCnt_q;
    logic [GAP_W-1:0]   gapCnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic               tone_q;
    logic [FREQ_W-1:0]  freq_q;
    logic               isRest_q;
    logic               done_q;

    note_event_t        pushEvent;
    note_event_t        headEvent;
    logic [EVENT_W-1:0] fifoData;
    logic               fifoEmpty;
    logic               fifoFull;
    logic               fifoPush;
    logic               fifoPop;

    logic [ACC_W-1:0]   accSum_d;
    logic               accWrap_d;
    logic               playLast_d;

    // Queue handshake. A push coinciding with flush is dropped, and the head
    // event is consumed only in an enabled LOAD cycle.
    always_comb begin
        pushEvent = '{note: in_note, octave: in_octave, beats: in_beats};
        headEvent = fifoData;
        fifoPush  = in_valid && !fifoFull && !flush;
        fifoPop   = (state_q == LOAD) && enable && !flush;
    end

    note_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (fifoPush),
        .data_i  (pushEvent),
        .pop_i   (fifoPop),
        .data_o  (fifoData),
        .empty_o (fifoEmpty),
        .full_o  (fifoFull)
    );

    // Phase accumulator step. Adding twice the frequency per cycle and
    // wrapping at CLK_HZ gives one half-period per wrap, i.e. one toggle.
    // The counters run down to zero, so the last PLAY cycle is the one where
    // both the tick and the beat counter have reached zero.
    always_comb begin
        accSum_d   = acc_q + ACC_W'({freq_q, 1'b0});
        accWrap_d  = (accSum_d >= CLK_HZ_C);
        playLast_d = (tickCnt_q == '0) && (beatCnt_q == '0);
    end

    // Sequencer FSM with registered outputs. flush overrides everything and
    // never produces a note_done; with enable low every register holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beatCnt_q <= '0;
            tickCnt_q <= '0;
            gapCnt_q  <= '0;
            acc_q     <= '0;
            tone_q    <= 1'b0;
            freq_q    <= '0;
            isRest_q  <= 1'b0;
            done_q    <= 1'b0;
        end else if (flush) begin
            state_q   <= IDLE;
            beatCnt_q <= '0;
            tickCnt_q <= '0;
            gapCnt_q  <= '0;
            acc_q     <= '0;
            tone_q    <= 1'b0;
            freq_q    <= '0;
            isRest_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (enable) begin
                unique case (state_q)
                    IDLE: begin
                        if (!fifoEmpty) begin
                            state_q <= LOAD;
                        end
                    end
                    LOAD: begin
                        acc_q     <= '0;
                        tone_q    <= 1'b0;
                        isRest_q  <= (headEvent.note == REST_NOTE);
                        beatCnt_q <= headEvent.beats - BEATS_W'(1);
                        tickCnt_q <= TICK_LAST;
                        if (headEvent.beats == '0) begin
                            // Zero-length event: report it and skip playback.
                            freq_q <= '0;
                            done_q <= 1'b1;
                            if (HAS_GAP) begin
                                state_q  <= GAP;
                                gapCnt_q <= GAP_LAST;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            freq_q  <= noteFreq(headEvent.note, headEvent.octave);
                            state_q <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (playLast_d) begin
                            done_q <= 1'b1;
                            tone_q <= 1'b0;
                            freq_q <= '0;
                            acc_q  <= '0;
                            if (HAS_GAP) begin
                                state_q  <= GAP;
                                gapCnt_q <= GAP_LAST;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            if (tickCnt_q == '0) begin
                                beatCnt_q <= beatCnt_q - BEATS_W'(1);
                                tickCnt_q <= TICK_LAST;
                            end else begin
                                tickCnt_q <= tickCnt_q - TICK_W'(1);
                            end
                            // A rest keeps the accumulator parked and the output low.
                            if (!isRest_q) begin
                                if (accWrap_d) begin
                                    acc_q  <= accSum_d - CLK_HZ_C;
                                    tone_q <= ~tone_q;
                                end else begin
                                    acc_q <= accSum_d;
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (gapCnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            gapCnt_q <= gapCnt_q - GAP_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Output ports are direct views of registers.
    always_comb begin
        in_ready  = !fifoFull;
        tone_out  = tone_q;
        cur_freq  = freq_q;
        busy      = (state_q != IDLE);
        note_done = done_q;
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer.
//
// Stimulus pushes the expected per-event result {freq, busy cycles, sounding
// cycles, tone transitions} into a queue as each event is offered; a monitor
// on the falling clock edge measures every event and compares it with the
// queue head when note_done pulses. Directed checks cover reset, flush,
// queue-full back-pressure and, on a second instance, the GAP phase.
module tb_note_sequencer;

    localparam int CLK_HZ = 10000;
    localparam int TPB    = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_note;
    logic [1:0]  in_octave;
    logic [3:0]  in_beats;
    logic        enable;
    logic        flush;
    logic        tone_out;
    logic [19:0] cur_freq;
    logic        busy;
    logic        note_done;

    logic        gValid;
    logic        gReady;
    logic [3:0]  gNote;
    logic [1:0]  gOctave;
    logic [3:0]  gBeats;
    logic        gEnable;
    logic        gFlush;
    logic        gTone;
    logic [19:0] gFreq;
    logic        gBusy;
    logic        gDone;

    always #5 clk = ~clk;

    note_sequencer #(
        .CLK_HZ         (CLK_HZ),
        .TICKS_PER_BEAT (TPB),
        .GAP_TICKS      (0),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_note   (in_note),
        .in_octave (in_octave),
        .in_beats  (in_beats),
        .enable    (enable),
        .flush     (flush),
        .tone_out  (tone_out),
        .cur_freq  (cur_freq),
        .busy      (busy),
        .note_done (note_done)
    );

    note_sequencer #(
        .CLK_HZ         (CLK_HZ),
        .TICKS_PER_BEAT (TPB),
        .GAP_TICKS      (3),
        .FIFO_DEPTH     (4)
    ) dutGap (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (gValid),
        .in_ready  (gReady),
        .in_note   (gNote),
        .in_octave (gOctave),
        .in_beats  (gBeats),
        .enable    (gEnable),
        .flush     (gFlush),
        .tone_out  (gTone),
        .cur_freq  (gFreq),
        .busy      (gBusy),
        .note_done (gDone)
    );

    typedef struct {
        int freq;
        int busyCycles;
        int freqCycles;
        int toggles;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   testCount = 0;
    int   failCount = 0;

    int   busyCnt   = 0;
    int   freqCnt   = 0;
    int   toggleCnt = 0;
    int   lastFreq  = 0;
    logic prevTone  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        testCount++;
        if (actual !== 32'(expected)) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        testCount++;
        failCount++;
        $display("[TB] FAIL %s: timed out", name);
    endtask

    // Monitor: measure each event between busy rising and note_done.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (busy === 1'b1) busyCnt++;
            if (cur_freq != 20'd0) begin
                freqCnt++;
                lastFreq = int'(cur_freq);
            end
            if (tone_out !== prevTone) toggleCnt++;
            if (note_done === 1'b1) begin
                if (expQ.size() == 0) begin
                    testCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected note_done: got 1, expected 0 (nothing pending)");
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("event freq", lastFreq, monExp.freq);
                    checkOutput("event busy cycles", busyCnt, monExp.busyCycles);
                    checkOutput("event sounding cycles", freqCnt, monExp.freqCycles);
                    checkOutput("event tone transitions", toggleCnt, monExp.toggles);
                end
            end
            if (busy !== 1'b1) begin
                busyCnt   = 0;
                freqCnt   = 0;
                toggleCnt = 0;
                lastFreq  = 0;
            end
        end else begin
            busyCnt   = 0;
            freqCnt   = 0;
            toggleCnt = 0;
            lastFreq  = 0;
        end
        prevTone = tone_out;
    end

    // Offer one event (called at a falling edge); optionally queue its result.
    task automatic applyStimulus(input logic [3:0] note, input logic [1:0] oct,
                                 input logic [3:0] beats, input bit expectDone,
                                 input int expFreq, input int expToggles,
                                 input int pauseCycles);
        exp_t e;
        int   n;
        in_note   = note;
        in_octave = oct;
        in_beats  = beats;
        in_valid  = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            reportTimeout("push handshake");
            in_valid = 1'b0;
            return;
        end
        if (expectDone) begin
            e.freq       = expFreq;
            e.busyCycles = int'(beats) * TPB + 1 + pauseCycles;
            e.freqCycles = (expFreq != 0) ? int'(beats) * TPB + pauseCycles : 0;
            e.toggles    = expToggles;
            expQ.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n = 0;
        while ((expQ.size() != 0 || busy !== 1'b0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0 || busy !== 1'b0) reportTimeout(name);
    endtask

    task automatic waitDone(input string name, input int limit);
        int n = 0;
        while (note_done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (note_done !== 1'b1) reportTimeout(name);
    endtask

    task automatic waitSounding(input string name, input int limit);
        int n = 0;
        while (cur_freq == 20'd0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (cur_freq == 20'd0) reportTimeout(name);
    endtask

    // One event on the GAP_TICKS=3 instance; busy must stay high for exactly
    // three samples starting with the note_done sample.
    task automatic gapRun(input logic [3:0] beats, input string name);
        int n;
        gNote   = 4'd9;
        gOctave = 2'd0;
        gBeats  = beats;
        gValid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        gValid = 1'b0;
        n = 0;
        while (gDone !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (gDone !== 1'b1) begin
            reportTimeout(name);
            return;
        end
        checkOutput({name, " freq in gap"}, gFreq, 0);
        checkOutput({name, " tone in gap"}, gTone, 0);
        n = 0;
        while (gBusy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checkOutput({name, " gap cycles"}, n, 3);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_note   = 4'd0;
        in_octave = 2'd0;
        in_beats  = 4'd0;
        enable    = 1'b1;
        flush     = 1'b0;
        gValid    = 1'b0;
        gNote     = 4'd0;
        gOctave   = 2'd0;
        gBeats    = 4'd0;
        gEnable   = 1'b1;
        gFlush    = 1'b0;

        // Reset state.
        #2;
        checkOutput("reset tone_out", tone_out, 0);
        checkOutput("reset cur_freq", cur_freq, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset note_done", note_done, 0);
        checkOutput("reset in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // A3 for one beat.
        applyStimulus(4'd9, 2'd0, 4'd1, 1'b1, 220, 44, 0);
        waitIdle("single note", 3000);

        // Same note paused for 50 cycles mid-play: duration stretches, pitch holds.
        applyStimulus(4'd9, 2'd0, 4'd1, 1'b1, 220, 44, 50);
        waitSounding("pause note start", 100);
        repeat (300) @(negedge clk);
        enable = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("paused busy", busy, 1);
        checkOutput("paused cur_freq", cur_freq, 220);
        enable = 1'b1;
        waitIdle("paused note", 3000);

        // Top note then a rest, back to back.
        applyStimulus(4'd11, 2'd3, 4'd2, 1'b1, 1975, 790, 0);
        applyStimulus(4'd15, 2'd0, 4'd1, 1'b1, 0, 0, 0);
        waitDone("first of pair", 3000);
        @(negedge clk);
        checkOutput("back-to-back reload", busy, 1);
        waitIdle("note then rest", 3000);

        // Paused queue fills: four accepted, fifth held until the first pop.
        enable = 1'b0;
        applyStimulus(4'd0,  2'd0, 4'd1, 1'b1, 130, 26, 0);
        applyStimulus(4'd4,  2'd2, 4'd1, 1'b1, 659, 132, 0);
        applyStimulus(4'd14, 2'd1, 4'd1, 1'b1, 293, 58, 0);
        checkOutput("ready with three queued", in_ready, 1);
        applyStimulus(4'd7,  2'd3, 4'd1, 1'b1, 1568, 314, 0);
        checkOutput("ready when full", in_ready, 0);
        checkOutput("busy while disabled", busy, 0);
        in_note   = 4'd12;
        in_octave = 2'd0;
        in_beats  = 4'd1;
        in_valid  = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("ready held off while full", in_ready, 0);
        enable = 1'b1;
        applyStimulus(4'd12, 2'd0, 4'd1, 1'b1, 130, 26, 0);
        waitIdle("full queue drain", 8000);

        // Zero-beat event is discarded with a pulse; the next one plays.
        applyStimulus(4'd5, 2'd0, 4'd0, 1'b1, 0, 0, 0);
        applyStimulus(4'd0, 2'd1, 4'd1, 1'b1, 261, 52, 0);
        waitDone("discard pulse", 100);
        checkOutput("discard cur_freq", cur_freq, 0);
        waitIdle("discard then note", 3000);

        // Flush 500 cycles into a note with two more queued; a push in the
        // flush cycle must be dropped.
        applyStimulus(4'd9, 2'd1, 4'd2, 1'b0, 0, 0, 0);
        applyStimulus(4'd2, 2'd0, 4'd1, 1'b0, 0, 0, 0);
        applyStimulus(4'd3, 2'd0, 4'd1, 1'b0, 0, 0, 0);
        waitSounding("flush note start", 100);
        checkOutput("flush note freq", cur_freq, 440);
        repeat (499) @(negedge clk);
        flush     = 1'b1;
        in_note   = 4'd4;
        in_octave = 2'd0;
        in_beats  = 4'd1;
        in_valid  = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush tone_out", tone_out, 0);
        checkOutput("flush cur_freq", cur_freq, 0);
        checkOutput("flush busy", busy, 0);
        checkOutput("flush in_ready", in_ready, 1);
        checkOutput("flush note_done", note_done, 0);
        repeat (20) @(negedge clk);
        checkOutput("idle after flush", busy, 0);

        // Asynchronous reset in the middle of PLAY.
        applyStimulus(4'd9, 2'd0, 4'd1, 1'b0, 0, 0, 0);
        applyStimulus(4'd4, 2'd0, 4'd1, 1'b0, 0, 0, 0);
        waitSounding("reset note start", 100);
        repeat (300) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset tone_out", tone_out, 0);
        checkOutput("async reset cur_freq", cur_freq, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset note_done", note_done, 0);
        checkOutput("async reset in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("queue discarded by reset", busy, 0);
        applyStimulus(4'd9, 2'd0, 4'd1, 1'b1, 220, 44, 0);
        waitIdle("post-reset note", 3000);

        // Gap timing on the GAP_TICKS=3 instance.
        gapRun(4'd1, "gap after note");
        gapRun(4'd0, "gap after discard");

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
